latch4bit_load_arbiter: RTL and testbench

- Round-robin controller that shares one 4-bit load-enabled storage register (latch4bit style: load, d, q) among four requesters.
- Accepts a request, drives load/d to the storage element for a programmable hold time, then acknowledges the winner.
- Keeps a shadow copy of the last value written.
- Sits between producer blocks and the shared register in the lab datapath.

---
 rtl/latch4bit_load_arbiter.sv | 108 ++++++++++
 tb/tb_latch4bit_load_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/latch4bit_load_arbiter.sv
// Round-robin arbiter sharing one load-enabled 4-bit register among four
// requesters. The winner's data is driven for HOLD cycles with load high,
// then a one-cycle ack goes back to the winner. q shadows the last value
// committed to the shared register.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request; arbitration happens here only
// LOAD  | load asserted, d held constant, hold counter running
// ACK   | one-cycle ack to owner; pointer advances on exit
module latch4bit_load_arbiter #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data,
    output logic               load,
    output logic [WIDTH-1:0]   d,
    output logic [3:0]         ack,
    output logic [1:0]         owner,
    output logic               busy,
    output logic [WIDTH-1:0]   q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] cnt;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;

    // First requesting index at or above the pointer, wrapping 3 -> 0.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Transfer sequencing with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            load  <= 1'b0;
            d     <= '0;
            ack   <= 4'b0000;
            owner <= 2'd0;
            busy  <= 1'b0;
            q     <= '0;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 4'b0000;
                    if (req != 4'b0000) begin
                        owner <= winner;
                        d     <= data[int'(winner)*WIDTH +: WIDTH];
                        load  <= 1'b1;
                        busy  <= 1'b1;
                        cnt   <= 4'(HOLD - 1);
                        state <= LOAD;
                    end else begin
                        load <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        load  <= 1'b0;
                        q     <= d;
                        ack   <= 4'b0001 << owner;
                        state <= ACK;
                    end
                end
                ACK: begin
                    ack   <= 4'b0000;
                    busy  <= 1'b0;
                    ptr   <= owner + 2'd1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    load  <= 1'b0;
                    ack   <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch4bit_load_arbiter.sv
// Directed bench for latch4bit_load_arbiter: one instance with HOLD=1 and
// one with HOLD=3, driven and sampled on the falling edge.
module tb_latch4bit_load_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst3;
    logic [3:0]  req1, req3;
    logic [15:0] data1, data3;
    logic        load1, load3, busy1, busy3;
    logic [3:0]  d1, d3, q1, q3, ack1, ack3;
    logic [1:0]  owner1, owner3;

    int tests = 0;
    int fails = 0;

    latch4bit_load_arbiter #(.WIDTH(4), .HOLD(1)) dut1 (
        .clk(clk), .reset(rst1), .req(req1), .data(data1),
        .load(load1), .d(d1), .ack(ack1), .owner(owner1), .busy(busy1), .q(q1)
    );

    latch4bit_load_arbiter #(.WIDTH(4), .HOLD(3)) dut3 (
        .clk(clk), .reset(rst3), .req(req3), .data(data3),
        .load(load3), .d(d3), .ack(ack3), .owner(owner3), .busy(busy3), .q(q3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst1 = 1'b1; req1 = 4'hF; data1 = 16'h4321;
        rst3 = 1'b1; req3 = 4'h0; data3 = 16'h0000;
        @(negedge clk);
        tick; tick;

        // reset values while requests are pending
        chk("rst_load",  32'(load1),  32'd0);
        chk("rst_ack",   32'(ack1),   32'd0);
        chk("rst_busy",  32'(busy1),  32'd0);
        chk("rst_owner", 32'(owner1), 32'd0);
        chk("rst_d",     32'(d1),     32'd0);
        chk("rst_q",     32'(q1),     32'd0);

        // fairness: req=1111 held, data 1,2,3,4 -> owners 0,1,2,3,0
        rst1 = 1'b0;
        for (int g = 0; g < 5; g++) begin
            tick;
            chk("rr_load",  32'(load1),  32'd1);
            chk("rr_owner", 32'(owner1), 32'(g % 4));
            chk("rr_d",     32'(d1),     32'((g % 4) + 1));
            chk("rr_busy",  32'(busy1),  32'd1);
            tick;
            chk("rr_ack",   32'(ack1),   32'(1 << (g % 4)));
            chk("rr_q",     32'(q1),     32'((g % 4) + 1));
            chk("rr_ack_load", 32'(load1), 32'd0);
            tick;
            chk("rr_idle_ack",  32'(ack1),  32'd0);
            chk("rr_idle_busy", 32'(busy1), 32'd0);
        end

        // single transfer, HOLD=1
        req1 = 4'b0001; data1 = 16'h000A;
        tick;
        chk("one_load", 32'(load1), 32'd1);
        chk("one_d",    32'(d1),    32'hA);
        tick;
        chk("one_ack",  32'(ack1),  32'b0001);
        chk("one_q",    32'(q1),    32'hA);
        chk("one_busy", 32'(busy1), 32'd1);
        req1 = 4'b0000;
        tick;
        chk("one_idle_load", 32'(load1), 32'd0);
        chk("one_idle_q",    32'(q1),    32'hA);
        chk("one_idle_busy", 32'(busy1), 32'd0);

        // pointer rotation: grant 2, then req=1001 -> 3 before 0
        req1 = 4'b0100; data1 = 16'h0700;
        tick;
        chk("rot_owner2", 32'(owner1), 32'd2);
        tick;
        chk("rot_ack2", 32'(ack1), 32'b0100);
        req1 = 4'b1001; data1 = 16'h9008;
        tick;
        chk("rot_idle_ack", 32'(ack1), 32'd0);
        tick;
        chk("rot_owner3", 32'(owner1), 32'd3);
        chk("rot_d3",     32'(d1),     32'h9);
        tick;
        chk("rot_ack3", 32'(ack1), 32'b1000);
        chk("rot_q3",   32'(q1),   32'h9);
        tick;
        tick;
        chk("rot_owner0", 32'(owner1), 32'd0);
        chk("rot_d0",     32'(d1),     32'h8);
        tick;
        chk("rot_ack0", 32'(ack1), 32'b0001);
        req1 = 4'b0000;
        tick;
        chk("rot_idle_owner", 32'(owner1), 32'd0);

        // req dropped during LOAD still completes
        req1 = 4'b0010; data1 = 16'h00B0;
        tick;
        chk("drop_load",  32'(load1),  32'd1);
        chk("drop_owner", 32'(owner1), 32'd1);
        req1 = 4'b0000; data1 = 16'h00F0;
        tick;
        chk("drop_ack", 32'(ack1), 32'b0010);
        chk("drop_q",   32'(q1),   32'hB);
        tick;
        chk("drop_idle_ack", 32'(ack1), 32'd0);

        // HOLD=3 transfer
        rst3 = 1'b0;
        tick;
        req3 = 4'b0100; data3 = 16'h0500;
        for (int c = 1; c <= 3; c++) begin
            tick;
            chk("h3_load", 32'(load3), 32'd1);
            chk("h3_d",    32'(d3),    32'h5);
            chk("h3_noack", 32'(ack3), 32'd0);
        end
        tick;
        chk("h3_ack",  32'(ack3),  32'b0100);
        chk("h3_q",    32'(q3),    32'h5);
        chk("h3_ack_load", 32'(load3), 32'd0);
        req3 = 4'b0000;
        tick;
        chk("h3_idle_q",    32'(q3),    32'h5);
        chk("h3_idle_busy", 32'(busy3), 32'd0);

        // reset during LOAD aborts the transfer
        req3 = 4'b0001; data3 = 16'h000C;
        tick;
        chk("ab_load", 32'(load3), 32'd1);
        chk("ab_d",    32'(d3),    32'hC);
        rst3 = 1'b1;
        tick;
        chk("ab_rst_load", 32'(load3), 32'd0);
        chk("ab_rst_busy", 32'(busy3), 32'd0);
        chk("ab_rst_q",    32'(q3),    32'd0);
        rst3 = 1'b0; req3 = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            tick;
            chk("ab_noack", 32'(ack3), 32'd0);
            chk("ab_q0",    32'(q3),   32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
